rx_dac_fanout: RTL and testbench
================================

// Module: rx_dac_fanout
// PURPOSE
//  Parametrised successor to the fixed 8-lane RX core output stage. Fans one multi-lane ADC sample bus
//  out to NUM_DAC DAC buses, each with its own digital gain, click-free soft mute/unmute ramp,
//  round-half-up scaling with saturation, and sticky clip flags. Gain and enable settings are taken
//  from shadow registers and applied atomically on a commit pulse. Sits between the central RX DSP
//  core outputs and the DAC lane interfaces.
// PARAMETERS
//  NUM_LANES   8   samples per clock per bus
//  NUM_DAC     3   number of DAC output buses
//  DATA_W      16  signed sample width
//  GAIN_W      8   unsigned gain width
//  GAIN_FRAC   6   gain fractional bits (0x40 = 1.0)
//  RAMP_LOG2   4   ramp length = 2**RAMP_LOG2 valid beats
// PORTS
//  clock       in   1                        single clock; all logic is synchronous to it
//  reset_n     in   1                        asynchronous, active-low reset
//  adc_data    in   DATA_W*NUM_LANES         lane k = bits [DATA_W*(k+1)-1 : DATA_W*k]
//  adc_valid   in   1                        qualifies adc_data
//  cfg_gain    in   GAIN_W*NUM_DAC           shadow gain, DAC d in slice d
//  cfg_enable  in   NUM_DAC                  shadow enable per DAC
//  cfg_commit  in   1                        1-cycle pulse: capture cfg_gain/cfg_enable
//  cfg_ack     out  1                        1-cycle pulse, 1 cycle after commit
//  sat_clear   in   1                        clears sat_flag
//  dac_data    out  NUM_DAC*NUM_LANES*DATA_W DAC d lane k at slice (d*NUM_LANES+k)
//  dac_valid   out  1                        adc_valid delayed 2 cycles
//  sat_flag    out  NUM_DAC                  sticky clip flag per DAC
//  dac_active  out  NUM_DAC                  1 while DAC d FSM is ACTIVE
// BEHAVIOUR
//  Reset: all outputs 0; gains 0; every ramp counter r=0; every FSM in MUTED. Reset asserted
//   mid-operation forces MUTED immediately, with no ramp-down.
//  Config:
//   - cfg_commit at cycle T loads the active gain/enable registers at T+1.
//   - cfg_ack pulses at T+1.
//   - A commit arriving while a previous one is still applying: the last one wins.
//  Per-DAC ramp FSM. r is in 0..2**RAMP_LOG2 and changes only on adc_valid beats:
//   MUTED     (r=0):            en=1 -> RAMP_UP
//   RAMP_UP:                    beat: r+=1, the beat uses the new r
//                               r reaches max -> ACTIVE
//                               en=0 -> RAMP_DOWN from the current r (no jump)
//   ACTIVE    (r=max):          en=0 -> RAMP_DOWN
//   RAMP_DOWN:                  beat: r-=1, the beat uses the new r
//                               r reaches 0 -> MUTED
//                               en=1 -> RAMP_UP from the current r
//   No adc_valid: r and the FSM state hold (state changes on en still occur).
//  Datapath, 2-stage pipeline:
//   - S1 registers adc_data and eff_g = gain*r (unsigned, GAIN_W+RAMP_LOG2+1 bits).
//   - S2 computes p = sample*eff_g (signed x unsigned), then
//     y = (p + 2**(SH-1)) >>> SH, where SH = GAIN_FRAC+RAMP_LOG2.
//   - y saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
//  Latency: adc_valid at cycle T gives dac_valid and dac_data at T+2.
//  dac_data holds its value while dac_valid=0.
//  MUTED gives exact 0 output.
//  sat_flag[d]: set when any lane of DAC d clips on a valid beat; cleared by sat_clear. Set wins if
//   both occur in the same cycle.
//  All DACs are independent; one adc_valid beat drives every DAC.
// TESTING
//  1 Ramp up:   gain 0x40, enable DAC0, commit, constant input 1000 on all lanes
//               -> beat outputs 63, 125, 188, ..., 1000 at beat 16
//               -> dac_active[0]=1 after beat 16; DAC1/2 stay 0.
//  2 Saturation: ACTIVE, gain 0xFF
//               -> input 20000 gives 32767; input -20000 gives -32768; sat_flag set
//               -> sat_clear clears it
//               -> simultaneous clip + clear leaves the flag set.
//  3 Reversal:  disable at r=8 while in RAMP_UP
//               -> r steps 7..0 over 8 beats, then MUTED with output 0
//               -> re-enable at r=3 resumes at 4.
//  4 Rounding:  ACTIVE, gain 0x20, inputs -3, 3, -1
//               -> outputs -1, 2, 0 (round half up).
//  5 Valid gaps: adc_valid pattern 1,0,0,1
//               -> r advances only twice; dac_valid reproduces the pattern 2 cycles later;
//                  data holds in the gaps.
//  6 Reset mid-ramp: assert reset_n=0 at r=5
//               -> outputs 0 and dac_active 0 immediately
//               -> after release, FSM is MUTED until a new commit.

Source files
------------

// File: rtl/rx_dac_fanout.sv
// rx_dac_fanout
//   Fans one multi-lane ADC sample bus out to NUM_DAC DAC buses. Each DAC has
//   its own gain, a click-free soft mute/unmute ramp, round-half-up scaling
//   with saturation and a sticky clip flag. Gain/enable settings are written
//   into shadow inputs and applied atomically on cfg_commit.
//
// Ports
//   clock       single clock
//   reset_n     asynchronous active-low reset
//   adc_data    NUM_LANES signed samples, lane k at [DATA_W*(k+1)-1 : DATA_W*k]
//   adc_valid   qualifies adc_data; ramps only advance on valid beats
//   cfg_gain    shadow gain per DAC (slice d)
//   cfg_enable  shadow enable per DAC
//   cfg_commit  one-cycle pulse capturing cfg_gain/cfg_enable
//   cfg_ack     one-cycle pulse the cycle after a commit
//   sat_clear   clears sat_flag (a clip in the same cycle wins)
//   dac_data    DAC d lane k at slice (d*NUM_LANES+k)
//   dac_valid   adc_valid delayed by two cycles
//   sat_flag    sticky clip flag per DAC
//   dac_active  high while the DAC ramp FSM is ACTIVE
//
// Ramp FSM (one per DAC)
//   state     | meaning
//   MUTED     | r = 0, output forced to exact zero
//   RAMP_UP   | enabled, r climbing one step per valid beat
//   ACTIVE    | enabled, r = 2**RAMP_LOG2 (full gain)
//   RAMP_DOWN | disabled, r falling one step per valid beat

module rx_dac_fanout #(
  parameter int NUM_LANES = 8,
  parameter int NUM_DAC   = 3,
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6,
  parameter int RAMP_LOG2 = 4
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [DATA_W*NUM_LANES-1:0]         adc_data,
  input  logic                                adc_valid,
  input  logic [GAIN_W*NUM_DAC-1:0]           cfg_gain,
  input  logic [NUM_DAC-1:0]                  cfg_enable,
  input  logic                                cfg_commit,
  output logic                                cfg_ack,
  input  logic                                sat_clear,
  output logic [NUM_DAC*NUM_LANES*DATA_W-1:0] dac_data,
  output logic                                dac_valid,
  output logic [NUM_DAC-1:0]                  sat_flag,
  output logic [NUM_DAC-1:0]                  dac_active
);

  localparam int R_W  = RAMP_LOG2 + 1;          // r spans 0..2**RAMP_LOG2 inclusive
  localparam int EG_W = GAIN_W + RAMP_LOG2 + 1; // gain*r
  localparam int SH   = GAIN_FRAC + RAMP_LOG2;
  localparam int P_W  = DATA_W + EG_W + 1;      // signed sample x zero-extended eff gain
  localparam int A_W  = P_W + 1;                // headroom for the rounding add
  localparam int Y_W  = A_W - SH;
  localparam int BUS_W = NUM_LANES * DATA_W;

  localparam logic [R_W-1:0]        R_MAX   = R_W'(1 << RAMP_LOG2);
  localparam logic signed [A_W-1:0] ROUND_K = {{(A_W-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_t;

  // Active configuration, loaded from the shadow inputs on commit.
  logic [GAIN_W*NUM_DAC-1:0] gain_act;
  logic [NUM_DAC-1:0]        en_act;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gain_act <= '0;
      en_act   <= '0;
      cfg_ack  <= 1'b0;
    end else begin
      cfg_ack <= cfg_commit;
      if (cfg_commit) begin
        gain_act <= cfg_gain;
        en_act   <= cfg_enable;
      end
    end
  end

  // Stage 1 sample capture, shared by all DACs.
  logic [DATA_W*NUM_LANES-1:0] s1_data;
  logic                        s1_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      dac_valid <= 1'b0;
    end else begin
      s1_valid  <= adc_valid;
      dac_valid <= s1_valid;
      if (adc_valid) s1_data <= adc_data;
    end
  end

  for (genvar d = 0; d < NUM_DAC; d++) begin : g_dac
    logic [GAIN_W-1:0]  gain_d;
    logic               en_d;
    ramp_state_t        state;
    ramp_state_t        state_nxt;
    logic [R_W-1:0]     r;
    logic [R_W-1:0]     r_new;
    logic               active_q;
    logic [EG_W-1:0]    eg_q;
    logic [BUS_W-1:0]   out_q;
    logic [BUS_W-1:0]   out_nxt;
    logic [NUM_LANES-1:0] lane_clip;
    logic               sat_q;

    assign gain_d = gain_act[d*GAIN_W +: GAIN_W];
    assign en_d   = en_act[d];

    // Ramp position after this cycle; the current beat is scaled by it.
    always_comb begin
      r_new = r;
      if (adc_valid) begin
        if (en_d && (r != R_MAX))
          r_new = r + R_W'(1);
        else if (!en_d && (r != '0))
          r_new = r - R_W'(1);
      end
    end

    // A direction change resumes from the current r, never jumps.
    always_comb begin
      state_nxt = state;
      unique case (state)
        MUTED: begin
          if (en_d) state_nxt = (r_new == R_MAX) ? ACTIVE : RAMP_UP;
        end
        RAMP_UP, RAMP_DOWN: begin
          if (en_d) state_nxt = (r_new == R_MAX) ? ACTIVE : RAMP_UP;
          else      state_nxt = (r_new == '0)    ? MUTED  : RAMP_DOWN;
        end
        ACTIVE: begin
          if (!en_d) state_nxt = (r_new == '0) ? MUTED : RAMP_DOWN;
        end
        default: state_nxt = MUTED;
      endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state    <= MUTED;
        r        <= '0;
        active_q <= 1'b0;
      end else begin
        state    <= state_nxt;
        r        <= r_new;
        active_q <= (state_nxt == ACTIVE);
      end
    end

    assign dac_active[d] = active_q;

    // Stage 1 effective gain; r = 0 makes the whole product zero, giving
    // an exact-zero output while muted.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)       eg_q <= '0;
      else if (adc_valid) eg_q <= EG_W'(gain_d) * EG_W'(r_new);
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic signed [DATA_W-1:0] smp;
      logic signed [P_W-1:0]    prod;
      logic signed [A_W-1:0]    acc;
      logic signed [Y_W-1:0]    y;
      logic                     pos_ovf;
      logic                     neg_ovf;

      assign smp  = $signed(s1_data[k*DATA_W +: DATA_W]);
      assign prod = P_W'(smp) * P_W'($signed({1'b0, eg_q}));
      assign acc  = A_W'(prod) + ROUND_K;
      assign y    = Y_W'(acc >>> SH);

      // Out of range whenever the bits above the output sign bit disagree with it.
      assign pos_ovf = ~y[Y_W-1] & (|y[Y_W-2:DATA_W-1]);
      assign neg_ovf =  y[Y_W-1] & ~(&y[Y_W-2:DATA_W-1]);
      assign lane_clip[k] = pos_ovf | neg_ovf;

      assign out_nxt[k*DATA_W +: DATA_W] =
        pos_ovf ? {1'b0, {(DATA_W-1){1'b1}}} :
        neg_ovf ? {1'b1, {(DATA_W-1){1'b0}}} :
                  y[DATA_W-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)      out_q <= '0;
      else if (s1_valid) out_q <= out_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                      sat_q <= 1'b0;
      else if (s1_valid && (|lane_clip)) sat_q <= 1'b1;
      else if (sat_clear)                sat_q <= 1'b0;
    end

    assign sat_flag[d] = sat_q;
    assign dac_data[d*BUS_W +: BUS_W] = out_q;
  end

endmodule

// File: tb/tb_rx_dac_fanout.sv
module tb_rx_dac_fanout;

  localparam int NL  = 8;
  localparam int ND  = 3;
  localparam int DW  = 16;
  localparam int GW  = 8;
  localparam int GF  = 6;
  localparam int RL  = 4;
  localparam int RMAX = 1 << RL;
  localparam int SH  = GF + RL;
  localparam int OW  = ND * NL * DW;

  logic              clock;
  logic              reset_n;
  logic [DW*NL-1:0]  adc_data;
  logic              adc_valid;
  logic [GW*ND-1:0]  cfg_gain;
  logic [ND-1:0]     cfg_enable;
  logic              cfg_commit;
  logic              cfg_ack;
  logic              sat_clear;
  logic [OW-1:0]     dac_data;
  logic              dac_valid;
  logic [ND-1:0]     sat_flag;
  logic [ND-1:0]     dac_active;

  rx_dac_fanout #(
    .NUM_LANES(NL), .NUM_DAC(ND), .DATA_W(DW),
    .GAIN_W(GW), .GAIN_FRAC(GF), .RAMP_LOG2(RL)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .cfg_gain(cfg_gain), .cfg_enable(cfg_enable), .cfg_commit(cfg_commit),
    .cfg_ack(cfg_ack), .sat_clear(sat_clear),
    .dac_data(dac_data), .dac_valid(dac_valid),
    .sat_flag(sat_flag), .dac_active(dac_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: ramp position per DAC, integer scaling, two-beat pipeline.
  int            m_gain [ND];
  bit            m_en   [ND];
  int            m_r    [ND];
  bit            m_v1;
  int            m_y1   [ND][NL];
  bit            m_c1   [ND];
  bit            m_vld;
  logic [OW-1:0] m_data;
  logic [ND-1:0] m_sat;
  logic [ND-1:0] m_act;
  bit            m_ack;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_gain[d] = 0; m_en[d] = 0; m_r[d] = 0; m_c1[d] = 0;
      for (int k = 0; k < NL; k++) m_y1[d][k] = 0;
    end
    m_v1 = 0; m_vld = 0; m_data = '0; m_sat = '0; m_act = '0; m_ack = 0;
  endtask

  // sample * gain * r / 2**SH, rounded half up, then clamped to the output range.
  function automatic int scale(input int s, input int g, input int r, output bit clip);
    longint p;
    longint y;
    p = longint'(s) * longint'(g) * longint'(r);
    y = longint'($floor(real'(p) / (2.0 ** SH) + 0.5));
    clip = 0;
    if (y > 32767)  begin y = 32767;  clip = 1; end
    if (y < -32768) begin y = -32768; clip = 1; end
    return int'(y);
  endfunction

  task automatic model_update();
    int s;
    bit c;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_vld = m_v1;
    for (int d = 0; d < ND; d++) begin
      if (m_v1 && m_c1[d]) m_sat[d] = 1'b1;
      else if (sat_clear)  m_sat[d] = 1'b0;
      if (m_v1)
        for (int k = 0; k < NL; k++) m_data[(d*NL+k)*DW +: DW] = 16'(m_y1[d][k]);
    end
    m_v1 = adc_valid;
    for (int d = 0; d < ND; d++) begin
      if (adc_valid) begin
        if (m_en[d]) m_r[d] = (m_r[d] < RMAX) ? m_r[d] + 1 : RMAX;
        else         m_r[d] = (m_r[d] > 0) ? m_r[d] - 1 : 0;
        m_c1[d] = 0;
        for (int k = 0; k < NL; k++) begin
          s = int'($signed(adc_data[k*DW +: DW]));
          m_y1[d][k] = scale(s, m_gain[d], m_r[d], c);
          if (c) m_c1[d] = 1;
        end
      end
      m_act[d] = m_en[d] && (m_r[d] == RMAX);
    end
    m_ack = cfg_commit;
    if (cfg_commit)
      for (int d = 0; d < ND; d++) begin
        m_gain[d] = int'(cfg_gain[d*GW +: GW]);
        m_en[d]   = cfg_enable[d];
      end
  endtask

  task automatic cycle();
    model_update();
    @(posedge clock);
    #1;
    chk("dac_valid", dac_valid, m_vld);
    chk_wide("dac_data", dac_data, m_data);
    chk("sat_flag", sat_flag, m_sat);
    chk("dac_active", dac_active, m_act);
    chk("cfg_ack", cfg_ack, m_ack);
  endtask

  function automatic logic signed [15:0] dac_lane(input int d, input int k);
    return dac_data[(d*NL+k)*DW +: DW];
  endfunction

  task automatic set_lanes(input int val);
    for (int k = 0; k < NL; k++) adc_data[k*DW +: DW] = 16'(val);
  endtask

  // One valid beat; the scaled result is on dac_data when this returns.
  task automatic beat(input int val, input bit clr_at_out);
    set_lanes(val);
    adc_valid = 1'b1;
    cycle();
    adc_valid = 1'b0;
    sat_clear = clr_at_out;
    cycle();
    sat_clear = 1'b0;
  endtask

  task automatic commit(input logic [GW*ND-1:0] g, input logic [ND-1:0] en, input bit clr);
    cfg_gain = g; cfg_enable = en; cfg_commit = 1'b1; sat_clear = clr;
    cycle();
    cfg_commit = 1'b0; sat_clear = 1'b0;
    chk("cfg_ack_pulse", cfg_ack, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  typedef struct {
    logic [7:0] gain;
    int         smp;
    int         exp_y;
    bit         exp_clip;
  } vec_t;

  vec_t vecs [13];
  int   exp_r [17];

  initial begin
    vecs[0]  = '{8'h40,   1000,   1000, 1'b0};
    vecs[1]  = '{8'hFF,  20000,  32767, 1'b1};
    vecs[2]  = '{8'hFF, -20000, -32768, 1'b1};
    vecs[3]  = '{8'h20,     -3,     -1, 1'b0};
    vecs[4]  = '{8'h20,      3,      2, 1'b0};
    vecs[5]  = '{8'h20,     -1,      0, 1'b0};
    vecs[6]  = '{8'h80,  16384,  32767, 1'b1};
    vecs[7]  = '{8'h80, -16384, -32768, 1'b0};
    vecs[8]  = '{8'h41,    100,    102, 1'b0};
    vecs[9]  = '{8'h00,  12345,      0, 1'b0};
    vecs[10] = '{8'h20,      1,      1, 1'b0};
    vecs[11] = '{8'h20,     -2,     -1, 1'b0};
    vecs[12] = '{8'h01,  32767,    512, 1'b0};
    // Output for input 1000 at gain 0x40 versus ramp position r.
    exp_r = '{0, 63, 125, 188, 250, 313, 375, 438, 500, 563, 625, 688, 750, 813, 875, 938, 1000};

    reset_n = 1'b0; adc_data = '0; adc_valid = 1'b0; cfg_gain = '0;
    cfg_enable = '0; cfg_commit = 1'b0; sat_clear = 1'b0;
    model_reset();
    cycle();
    cycle();
    chk("rst_dac_data_zero", (dac_data == '0), 1);
    chk("rst_active", dac_active, 0);
    chk("rst_valid", dac_valid, 0);
    reset_n = 1'b1;
    cycle();

    // Ramp up DAC0 only.
    commit({8'h40, 8'h40, 8'h40}, 3'b001, 1'b0);
    for (int i = 1; i <= RMAX; i++) begin
      beat(1000, 1'b0);
      chk($sformatf("ramp_up_r%0d", i), dac_lane(0, 0), exp_r[i]);
      if (i == RMAX - 1) chk("active_before_end", dac_active, 0);
    end
    chk("ramp_up_lane7", dac_lane(0, 7), 1000);
    chk("active_after_ramp", dac_active, 3'b001);
    chk("dac1_muted", dac_lane(1, 0), 0);
    chk("dac2_muted", dac_lane(2, 3), 0);

    // Table: DAC0 at full ramp, one gain/sample pair per row.
    for (int i = 0; i < 13; i++) begin
      commit({8'h00, 8'h00, vecs[i].gain}, 3'b001, 1'b1);
      beat(vecs[i].smp, 1'b0);
      chk($sformatf("vec%0d_lane0", i), dac_lane(0, 0), vecs[i].exp_y);
      chk($sformatf("vec%0d_lane5", i), dac_lane(0, 5), vecs[i].exp_y);
      chk($sformatf("vec%0d_sat", i), sat_flag[0], vecs[i].exp_clip);
    end

    // Sticky flag, clear, and clip winning over a simultaneous clear.
    commit({8'h00, 8'h00, 8'hFF}, 3'b001, 1'b1);
    beat(20000, 1'b0);
    chk("sat_set", sat_flag, 3'b001);
    sat_clear = 1'b1;
    cycle();
    sat_clear = 1'b0;
    chk("sat_cleared", sat_flag, 3'b000);
    beat(-20000, 1'b1);
    chk("sat_clip_beats_clear", sat_flag, 3'b001);
    chk("sat_neg_value", dac_lane(0, 2), -32768);

    // Reversal mid-ramp.
    do_reset();
    commit({8'h00, 8'h00, 8'h40}, 3'b001, 1'b0);
    for (int i = 0; i < 8; i++) beat(1000, 1'b0);
    chk("rev_at_r8", dac_lane(0, 0), 500);
    commit({8'h00, 8'h00, 8'h40}, 3'b000, 1'b0);
    for (int r = 7; r >= 0; r--) begin
      beat(1000, 1'b0);
      chk($sformatf("ramp_down_r%0d", r), dac_lane(0, 0), exp_r[r]);
    end
    chk("muted_active", dac_active, 0);
    beat(1000, 1'b0);
    chk("muted_zero", dac_lane(0, 1), 0);
    commit({8'h00, 8'h00, 8'h40}, 3'b001, 1'b0);
    for (int i = 0; i < 5; i++) beat(1000, 1'b0);
    commit({8'h00, 8'h00, 8'h40}, 3'b000, 1'b0);
    beat(1000, 1'b0);
    beat(1000, 1'b0);
    chk("rev_down_r3", dac_lane(0, 0), 188);
    commit({8'h00, 8'h00, 8'h40}, 3'b001, 1'b0);
    beat(1000, 1'b0);
    chk("rev_resume_r4", dac_lane(0, 0), 250);

    // Valid gaps: pattern 1,0,0,1.
    do_reset();
    commit({8'h00, 8'h00, 8'h40}, 3'b001, 1'b0);
    set_lanes(1000);
    adc_valid = 1'b1; cycle();
    adc_valid = 1'b0; cycle();
    chk("gap_v0", dac_valid, 1);
    chk("gap_d0", dac_lane(0, 0), 63);
    cycle();
    chk("gap_v1", dac_valid, 0);
    chk("gap_hold1", dac_lane(0, 0), 63);
    adc_valid = 1'b1; cycle();
    adc_valid = 1'b0;
    chk("gap_v2", dac_valid, 0);
    chk("gap_hold2", dac_lane(0, 0), 63);
    cycle();
    chk("gap_v3", dac_valid, 1);
    chk("gap_r2", dac_lane(0, 0), 125);

    // Reset mid-ramp at r=5.
    do_reset();
    commit({8'h40, 8'h40, 8'h40}, 3'b111, 1'b0);
    for (int i = 0; i < 5; i++) beat(1000, 1'b0);
    chk("pre_reset_r5", dac_lane(2, 0), 313);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_data", (dac_data == '0), 1);
    chk("async_rst_active", dac_active, 0);
    chk("async_rst_valid", dac_valid, 0);
    model_reset();
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) beat(1000, 1'b0);
    chk("post_rst_muted", (dac_data == '0), 1);
    chk("post_rst_valid", dac_valid, 1);
    chk("post_rst_active", dac_active, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      adc_valid  = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NL; k++) begin
        case ($urandom_range(0, 3))
          0: adc_data[k*DW +: DW] = 16'($urandom);
          1: adc_data[k*DW +: DW] = 16'(int'($urandom_range(0, 128)) - 64);
          2: adc_data[k*DW +: DW] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
          default: adc_data[k*DW +: DW] = 16'($urandom_range(0, 4000));
        endcase
      end
      cfg_commit = ($urandom_range(0, 19) == 0);
      cfg_gain   = 24'($urandom);
      cfg_enable = 3'($urandom);
      sat_clear  = ($urandom_range(0, 9) == 0);
      cycle();
    end
    cfg_commit = 1'b0; sat_clear = 1'b0; adc_valid = 1'b0;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
